stage3_exam: RTL and testbench
==============================

// Module: stage3_exam
// PURPOSE
//  Third stage of the pass/bonus chain. Consumes the stage-2 verdict (pass2, bonus2) through a
//  valid/ready handshake, then accumulates N per-cycle effort samples. It scores their average
//  plus bonus and luck against a difficulty level, and emits pass3/bonus3 with a burnout flag.
//  Multi-cycle and registered; sits directly downstream of stage2 and feeds stage 4 or the scoreboard.
// PARAMETERS
//  SESS_LOG2      2    log2 of number of effort samples per exam (N = 1<<SESS_LOG2)
//  FATIGUE_LIMIT  360  running effort sum strictly above this => burnout (width ACC_W)
//  ACC_W          7+SESS_LOG2  accumulator width (derived localparam, not overridable)
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  upstream verdict valid
//  in_ready   out  1  high only in IDLE
//  pass2      in   1  stage-2 pass
//  bonus2     in   2  stage-2 bonus (0..3)
//  hard       in   7  difficulty 0..100, sampled at accept
//  luck       in   2  luck 0..3, sampled at accept
//  work       in   7  effort sample; values >100 saturate to 100
//  work_valid in   1  work sample present this cycle (counted only in STUDY)
//  out_valid  out  1  result valid, held until out_ready
//  out_ready  in   1  downstream accepts result
//  pass3      out  1  exam passed
//  bonus3     out  2  bonus carried forward
//  burnout    out  1  effort sum exceeded FATIGUE_LIMIT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; acc, sess_cnt, latched inputs cleared;
//   out_valid, pass3, bonus3 and burnout = 0; in_ready = 1 (decoded from state).
//  States and transitions:
//   IDLE:  in_ready=1. If in_valid, latch pass2, bonus2, hard and luck.
//          pass2=1: go to STUDY, acc=0, sess_cnt=0.
//          pass2=0: go to DONE with pass3=0, bonus3=0, burnout=0 (failure propagates; no STUDY).
//   STUDY: on each edge with work_valid=1: w=min(work,100); nsum=acc+w; acc<=nsum; sess_cnt++.
//          If nsum>FATIGUE_LIMIT: set burnout, go to JUDGE immediately (early exit).
//          Else if this was sample N: go to JUDGE. Cycles with work_valid=0 are stalls.
//   JUDGE: one cycle. avg=acc>>SESS_LOG2; score=min(avg+4*bonus2+4*luck, 100).
//          pass3 = !burnout && (score>hard) (strict).
//          bonus3 = pass3 ? score[6:5] : 0.
//          Register the results; go to DONE.
//   DONE:  out_valid=1; pass3, bonus3 and burnout held stable.
//          If out_ready: out_valid<=0, go to IDLE. The accept edge clears the result registers.
//  Arithmetic: every sum is computed at ACC_W+1 bits, so there is no overflow.
//   With defaults, max acc is 400 and max pre-saturation score is 124.
//  Latency, from the accept edge E0 with back-to-back samples:
//   samples arrive at E1..EN, JUDGE at E(N+1), out_valid high after E(N+1).
//   On the pass2=0 path, out_valid is high after E0.
//  Boundaries:
//   - in_valid outside IDLE is ignored and not latched.
//   - work_valid outside STUDY is ignored.
//   - nsum equal to FATIGUE_LIMIT is not burnout.
//   - score equal to hard fails.
//   - Result is held indefinitely under backpressure.
//   - A new transaction is accepted no earlier than the cycle after out handshake (IDLE re-entry).
//   - Reset in any state aborts the transaction immediately; the partial result is discarded.
// TESTING
//  1. pass2=0, bonus2=3 -> out_valid after accept edge; pass3=0, bonus3=0, burnout=0; no work consumed.
//  2. pass2=1, bonus2=2, luck=1, hard=50; work 80,80,80,80 back-to-back -> acc=320, score=92;
//     pass3=1, bonus3=2, burnout=0; out_valid after E5.
//  3. pass2=1, hard=10; work 100,100,100,70 -> nsum=370>360: burnout=1, pass3=0, bonus3=0.
//     Repeat with FATIGUE_LIMIT=150 and work 100,100 -> early JUDGE after 2nd sample.
//  4. bonus2=3, luck=3, hard=100; work 127,90,90,80 -> 127 saturates to 100, acc=360 (no burnout);
//     score 114 saturates to 100; 100>100 false -> pass3=0.
//     Same stimulus with hard=99 -> pass3=1, bonus3=3.
//  5. Case 2 with out_ready low 3 cycles and work_valid gaps -> outputs stable, in_ready=0;
//     extra in_valid is ignored; gaps only add latency; results are unchanged.
//  6. rst_n low mid-STUDY after 2 samples -> out_valid=0, in_ready=1 at once;
//     next case-2 transaction yields pass3=1, bonus3=2.

Source files
------------

// File: rtl/stage3_exam.sv
// Stage-3 exam: accepts the stage-2 verdict, accumulates N effort samples,
// scores average + bonus + luck against difficulty and reports pass/bonus/burnout.
module stage3_exam #(
    parameter int unsigned SESS_LOG2     = 2,
    parameter int unsigned FATIGUE_LIMIT = 360
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       pass2,
    input  logic [1:0] bonus2,
    input  logic [6:0] hard,
    input  logic [1:0] luck,
    input  logic [6:0] work,
    input  logic       work_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       pass3,
    output logic [1:0] bonus3,
    output logic       burnout
);

    localparam int unsigned ACC_W  = 7 + SESS_LOG2;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = SESS_LOG2 + 1;
    localparam int unsigned N_SAMP = 1 << SESS_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STUDY = 2'd1,
        S_JUDGE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         bonus_q, bonus_d;
    logic [6:0]         hard_q, hard_d;
    logic [1:0]         luck_q, luck_d;
    logic               out_valid_q, out_valid_d;
    logic               pass3_q, pass3_d;
    logic [1:0]         bonus3_q, bonus3_d;
    logic               burnout_q, burnout_d;

    logic [6:0]         w_sat;
    logic [SUM_W-1:0]   nsum;
    logic [SUM_W-1:0]   avg;
    logic [SUM_W-1:0]   raw_score;
    logic [SUM_W-1:0]   score;
    logic               pass_c;

    // Datapath: saturated sample, running sum and clamped score
    always_comb begin
        w_sat     = (work > 7'd100) ? 7'd100 : work;
        nsum      = SUM_W'(acc_q) + SUM_W'(w_sat);
        avg       = SUM_W'(acc_q >> SESS_LOG2);
        raw_score = avg + SUM_W'({bonus_q, 2'b00}) + SUM_W'({luck_q, 2'b00});
        score     = (raw_score > SUM_W'(100)) ? SUM_W'(100) : raw_score;
        pass_c    = !burnout_q && (score > SUM_W'(hard_q));
    end

    // Next-state and result-register logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bonus_d     = bonus_q;
        hard_d      = hard_q;
        luck_d      = luck_q;
        out_valid_d = out_valid_q;
        pass3_d     = pass3_q;
        bonus3_d    = bonus3_q;
        burnout_d   = burnout_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bonus_d   = bonus2;
                    hard_d    = hard;
                    luck_d    = luck;
                    acc_d     = '0;
                    cnt_d     = '0;
                    pass3_d   = 1'b0;
                    bonus3_d  = 2'd0;
                    burnout_d = 1'b0;
                    if (pass2) begin
                        state_d = S_STUDY;
                    end else begin
                        // Upstream failure skips the exam entirely
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_STUDY: begin
                if (work_valid) begin
                    acc_d = ACC_W'(nsum);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (nsum > SUM_W'(FATIGUE_LIMIT)) begin
                        burnout_d = 1'b1;
                        state_d   = S_JUDGE;
                    end else if (cnt_q == CNT_W'(N_SAMP - 1)) begin
                        state_d = S_JUDGE;
                    end
                end
            end
            S_JUDGE: begin
                pass3_d     = pass_c;
                bonus3_d    = pass_c ? 2'(score >> 5) : 2'd0;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pass3_d     = 1'b0;
                    bonus3_d    = 2'd0;
                    burnout_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bonus_q     <= 2'd0;
            hard_q      <= 7'd0;
            luck_q      <= 2'd0;
            out_valid_q <= 1'b0;
            pass3_q     <= 1'b0;
            bonus3_q    <= 2'd0;
            burnout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bonus_q     <= bonus_d;
            hard_q      <= hard_d;
            luck_q      <= luck_d;
            out_valid_q <= out_valid_d;
            pass3_q     <= pass3_d;
            bonus3_q    <= bonus3_d;
            burnout_q   <= burnout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign pass3     = pass3_q;
    assign bonus3    = bonus3_q;
    assign burnout   = burnout_q;

endmodule

// File: tb/tb_stage3_exam.sv
// Bench for stage3_exam: directed cases plus randomized transactions against a score model.
module tb_stage3_exam;

    logic       clk;
    logic       rst_n;
    logic       pass2;
    logic [1:0] bonus2;
    logic [6:0] hard;
    logic [1:0] luck;
    logic [6:0] work;

    logic       iv_a, wv_a, or_a, ir_a, ov_a, p3_a, bo_a;
    logic [1:0] b3_a;
    logic       iv_b, wv_b, or_b, ir_b, ov_b, p3_b, bo_b;
    logic [1:0] b3_b;

    int n_vec = 0;
    int n_err = 0;

    stage3_exam dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .pass2(pass2), .bonus2(bonus2), .hard(hard), .luck(luck),
        .work(work), .work_valid(wv_a), .out_valid(ov_a), .out_ready(or_a),
        .pass3(p3_a), .bonus3(b3_a), .burnout(bo_a)
    );

    stage3_exam #(.FATIGUE_LIMIT(150)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .pass2(pass2), .bonus2(bonus2), .hard(hard), .luck(luck),
        .work(work), .work_valid(wv_b), .out_valid(ov_b), .out_ready(or_b),
        .pass3(p3_b), .bonus3(b3_b), .burnout(bo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit sel, input logic ir, input logic ov,
                            input logic p, input logic [1:0] b, input logic bo);
        chk({tag, ".in_ready"},  sel ? ir_b : ir_a, ir);
        chk({tag, ".out_valid"}, sel ? ov_b : ov_a, ov);
        chk({tag, ".pass3"},     sel ? p3_b : p3_a, p);
        chk({tag, ".bonus3"},    sel ? b3_b : b3_a, b);
        chk({tag, ".burnout"},   sel ? bo_b : bo_a, bo);
    endtask

    task automatic set_iv(input bit sel, input logic v);
        if (sel) iv_b = v; else iv_a = v;
    endtask
    task automatic set_wv(input bit sel, input logic v);
        if (sel) wv_b = v; else wv_a = v;
    endtask
    task automatic set_or(input bit sel, input logic v);
        if (sel) or_b = v; else or_a = v;
    endtask

    // Exam outcome from the rules: sum saturated samples, stop once over the limit,
    // average over four sessions, add 4*bonus and 4*luck, clamp at 100.
    task automatic model(input bit p2, input int b2, input int hd, input int lk,
                         input logic [3:0][6:0] w, input int limit,
                         output bit ep, output int eb, output bit eburn, output int ns);
        int sum, avg, score, wv;
        ep = 0; eb = 0; eburn = 0; ns = 0; sum = 0;
        if (p2) begin
            for (int i = 0; i < 4; i++) begin
                wv  = (int'(w[i]) > 100) ? 100 : int'(w[i]);
                sum = sum + wv;
                ns  = ns + 1;
                if (sum > limit) begin
                    eburn = 1;
                    break;
                end
            end
            avg   = sum / 4;
            score = avg + 4 * b2 + 4 * lk;
            if (score > 100) score = 100;
            ep = !eburn && (score > hd);
            eb = ep ? (score / 32) % 4 : 0;
        end
    endtask

    // One full transaction: accept, samples with random stalls, backpressure, release
    task automatic txn(input string tag, input bit sel, input bit p2, input logic [1:0] b2,
                       input logic [6:0] hd, input logic [1:0] lk, input logic [3:0][6:0] w,
                       input int gap_max, input int bp, input bit extra_iv);
        bit ep, eburn;
        int eb, ns, gaps;
        model(p2, int'(b2), int'(hd), int'(lk), w, sel ? 150 : 360, ep, eb, eburn, ns);

        @(negedge clk);
        chk_outs({tag, "/idle"}, sel, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        pass2 = p2; bonus2 = b2; hard = hd; luck = lk;
        work = 7'($urandom);
        set_wv(sel, 1'b1);
        set_iv(sel, 1'b1);

        @(negedge clk);
        pass2 = 1'($urandom); bonus2 = 2'($urandom); hard = 7'($urandom); luck = 2'($urandom);
        set_iv(sel, extra_iv);
        set_wv(sel, 1'b0);
        if (p2) begin
            chk_outs({tag, "/study"}, sel, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            for (int i = 0; i < ns; i++) begin
                gaps = $urandom_range(0, gap_max);
                for (int g = 0; g < gaps; g++) begin
                    set_wv(sel, 1'b0);
                    work = 7'($urandom);
                    @(negedge clk);
                    chk({tag, "/gap.out_valid"}, sel ? ov_b : ov_a, 1'b0);
                end
                set_wv(sel, 1'b1);
                work = w[i];
                @(negedge clk);
            end
            set_wv(sel, 1'($urandom));
            work = 7'($urandom);
            chk({tag, "/judge.out_valid"}, sel ? ov_b : ov_a, 1'b0);
            chk({tag, "/judge.in_ready"},  sel ? ir_b : ir_a, 1'b0);
            @(negedge clk);
        end

        set_or(sel, 1'b0);
        for (int c = 0; c < bp; c++) begin
            set_wv(sel, 1'($urandom));
            chk_outs({tag, "/hold"}, sel, 1'b0, 1'b1, ep, 2'(eb), eburn);
            @(negedge clk);
        end
        chk_outs({tag, "/done"}, sel, 1'b0, 1'b1, ep, 2'(eb), eburn);
        set_iv(sel, 1'b0);
        set_wv(sel, 1'b0);
        set_or(sel, 1'b1);
        @(negedge clk);
        chk_outs({tag, "/release"}, sel, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        set_or(sel, 1'b0);
    endtask

    initial begin
        logic [3:0][6:0] w;
        rst_n = 1'b0;
        pass2 = 1'b0; bonus2 = 2'd0; hard = 7'd0; luck = 2'd0; work = 7'd0;
        iv_a = 1'b0; wv_a = 1'b0; or_a = 1'b0;
        iv_b = 1'b0; wv_b = 1'b0; or_b = 1'b0;

        #12;
        chk_outs("reset_a", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk_outs("reset_b", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        txn("c1_fail_path", 1'b0, 1'b0, 2'd3, 7'd50, 2'd1, {4{7'd80}}, 0, 0, 1'b0);
        txn("c2_pass",      1'b0, 1'b1, 2'd2, 7'd50, 2'd1, {4{7'd80}}, 0, 0, 1'b0);
        txn("c3_burnout",   1'b0, 1'b1, 2'd0, 7'd10, 2'd0,
            {7'd70, 7'd100, 7'd100, 7'd100}, 0, 0, 1'b0);
        txn("c3_early",     1'b1, 1'b1, 2'd0, 7'd10, 2'd0,
            {7'd0, 7'd0, 7'd100, 7'd100}, 0, 0, 1'b0);
        txn("c4_eq_hard",   1'b0, 1'b1, 2'd3, 7'd100, 2'd3,
            {7'd80, 7'd90, 7'd90, 7'd127}, 0, 0, 1'b0);
        txn("c4_hard99",    1'b0, 1'b1, 2'd3, 7'd99, 2'd3,
            {7'd80, 7'd90, 7'd90, 7'd127}, 0, 0, 1'b0);
        txn("c5_backpress", 1'b0, 1'b1, 2'd2, 7'd50, 2'd1, {4{7'd80}}, 2, 3, 1'b1);

        // Reset in the middle of STUDY after two samples
        @(negedge clk);
        pass2 = 1'b1; bonus2 = 2'd2; hard = 7'd50; luck = 2'd1;
        iv_a = 1'b1;
        @(negedge clk);
        iv_a = 1'b0; wv_a = 1'b1; work = 7'd80;
        @(negedge clk);
        work = 7'd80;
        @(negedge clk);
        wv_a = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_outs("c6_reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("c6_after", 1'b0, 1'b1, 2'd2, 7'd50, 2'd1, {4{7'd80}}, 0, 0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 4; i++) w[i] = 7'($urandom_range(40, 127));
            txn("rand_a", 1'b0, ($urandom_range(0, 3) != 0), 2'($urandom), 7'($urandom_range(0, 100)),
                2'($urandom), w, 2, $urandom_range(0, 3), 1'($urandom));
        end
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) w[i] = 7'($urandom_range(0, 90));
            txn("rand_b", 1'b1, 1'b1, 2'($urandom), 7'($urandom_range(0, 100)),
                2'($urandom), w, 2, $urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
